forwarding_hazard_unit: RTL and testbench

Successor to the decode-stage forwarding unit. Generalised to N_SRC source operands, with load-use hazard detection added. A stall FSM holds the PC and IF/ID and injects bubbles until load data can be forwarded from MEM/WB. The block also keeps a saturating stall-cycle counter for the debug unit. It sits beside the ID stage and feeds the operand muxes, PC/IF-ID write enables and the ID/EX bubble mux.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/forwarding_select.sv | 71 +++++++
 rtl/forwarding_hazard_unit.sv | 169 ++++++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the decode-stage forwarding and hazard logic.
// Holds the forward-select encodings, the stall FSM state encoding, the
// load-use stall length and a small helper used to combine per-source needs.
package mips_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EX_MEM  = 2'b01;
    localparam logic [1:0] FWD_MEM_WB  = 2'b10;
    localparam logic [1:0] FWD_ID_EX   = 2'b11;

    // Stall cycles required when the consumer sits directly behind a load.
    localparam logic [1:0] LOAD_USE_STALL = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } stall_state_t;

    // Larger of two stall-need values.
    function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] r;
        if (a > b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/forwarding_select.sv
// Per-source forwarding compare chain.
// Compares one decode-stage source register against the destinations held in
// ID/EX, EX/MEM and MEM/WB, picks the youngest producer, and reports how many
// stall cycles a load producer still needs before its data can be forwarded.
// Ports:
//   i_src_addr / i_src_used         : source register and whether it is read
//   i_rd_* / i_reg_wr_*             : destination and write flag per stage
//   i_mem_read_id_ex / _ex_mem      : stage holds a load
//   o_forward                       : operand mux select (mips_pkg FWD_*)
//   o_need                          : 2 = adjacent load-use, 1 = one apart, 0 = none
module forwarding_select
    import mips_pkg::*;
#(
    parameter int NB_REG_ADDRESS       = 5,
    parameter int NB_FORWARDING_ENABLE = 2
) (
    input  logic [NB_REG_ADDRESS-1:0]       i_src_addr,
    input  logic                            i_src_used,
    input  logic [NB_REG_ADDRESS-1:0]       i_rd_id_ex,
    input  logic [NB_REG_ADDRESS-1:0]       i_rd_ex_mem,
    input  logic [NB_REG_ADDRESS-1:0]       i_rd_mem_wb,
    input  logic                            i_reg_wr_id_ex,
    input  logic                            i_reg_wr_ex_mem,
    input  logic                            i_reg_wr_mem_wb,
    input  logic                            i_mem_read_id_ex,
    input  logic                            i_mem_read_ex_mem,
    output logic [NB_FORWARDING_ENABLE-1:0] o_forward,
    output logic [1:0]                      o_need
);

    logic src_live_s;
    logic match_id_ex_s;
    logic match_ex_mem_s;
    logic match_mem_wb_s;

    // Stage matches; r0 and unused sources never match anything.
    always_comb begin
        src_live_s     = i_src_used & (i_src_addr != {NB_REG_ADDRESS{1'b0}});
        match_id_ex_s  = src_live_s & i_reg_wr_id_ex  & (i_rd_id_ex  == i_src_addr);
        match_ex_mem_s = src_live_s & i_reg_wr_ex_mem & (i_rd_ex_mem == i_src_addr);
        match_mem_wb_s = src_live_s & i_reg_wr_mem_wb & (i_rd_mem_wb == i_src_addr);
    end

    // Youngest producer wins the forward select.
    always_comb begin
        o_forward = NB_FORWARDING_ENABLE'(FWD_REGFILE);
        if (match_id_ex_s) begin
            o_forward = NB_FORWARDING_ENABLE'(FWD_ID_EX);
        end else if (match_ex_mem_s) begin
            o_forward = NB_FORWARDING_ENABLE'(FWD_EX_MEM);
        end else if (match_mem_wb_s) begin
            o_forward = NB_FORWARDING_ENABLE'(FWD_MEM_WB);
        end else begin
            o_forward = NB_FORWARDING_ENABLE'(FWD_REGFILE);
        end
    end

    // Load data is only forwardable from MEM/WB, so a load further up the
    // pipe costs one stall cycle per stage it still has to travel.
    always_comb begin
        o_need = 2'd0;
        if (match_id_ex_s && i_mem_read_id_ex) begin
            o_need = LOAD_USE_STALL;
        end else if (match_ex_mem_s && i_mem_read_ex_mem) begin
            o_need = 2'd1;
        end else begin
            o_need = 2'd0;
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Decode-stage forwarding and load-use hazard unit.
// Produces per-source operand forward selects, detects load-use hazards and
// runs a small stall FSM that holds PC/IF-ID and bubbles ID/EX until the load
// reaches MEM/WB. Also keeps a saturating stalled-cycle counter for debug.
// Ports:
//   i_clock, i_reset (sync, active low), i_enable (0 freezes state), i_flush
//   i_src_addr / i_src_used : packed decode sources, src k at [k*NB_REG_ADDRESS +: NB_REG_ADDRESS]
//   i_rd_*, i_reg_wr_*, i_mem_read_* : pipeline producer information
//   o_forward               : packed per-source selects, same packing as sources
//   o_stall / o_bubble_id_ex: hold PC+IF/ID, squash ID/EX controls
//   o_stall_count           : saturating count of stalled, enabled cycles
module forwarding_hazard_unit
    import mips_pkg::*;
#(
    parameter int NB_REG_ADDRESS       = 5,
    parameter int N_SRC                = 2,
    parameter int NB_FORWARDING_ENABLE = 2,
    parameter int NB_STALL_COUNT       = 32
) (
    input  logic                                  i_clock,
    input  logic                                  i_reset,
    input  logic                                  i_enable,
    input  logic                                  i_flush,
    input  logic [N_SRC*NB_REG_ADDRESS-1:0]       i_src_addr,
    input  logic [N_SRC-1:0]                      i_src_used,
    input  logic [NB_REG_ADDRESS-1:0]             i_rd_id_ex,
    input  logic [NB_REG_ADDRESS-1:0]             i_rd_ex_mem,
    input  logic [NB_REG_ADDRESS-1:0]             i_rd_mem_wb,
    input  logic                                  i_reg_wr_id_ex,
    input  logic                                  i_reg_wr_ex_mem,
    input  logic                                  i_reg_wr_mem_wb,
    input  logic                                  i_mem_read_id_ex,
    input  logic                                  i_mem_read_ex_mem,
    output logic [N_SRC*NB_FORWARDING_ENABLE-1:0] o_forward,
    output logic                                  o_stall,
    output logic                                  o_bubble_id_ex,
    output logic [NB_STALL_COUNT-1:0]             o_stall_count
);

    logic [N_SRC*NB_FORWARDING_ENABLE-1:0] fwd_s;
    logic [N_SRC*2-1:0]                    need_s;
    logic [1:0]                            need_max_s;
    logic                                  stall_s;

    stall_state_t              state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [NB_STALL_COUNT-1:0] count_q, count_d;

    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        forwarding_select #(
            .NB_REG_ADDRESS      (NB_REG_ADDRESS),
            .NB_FORWARDING_ENABLE(NB_FORWARDING_ENABLE)
        ) u_select (
            .i_src_addr       (i_src_addr[k*NB_REG_ADDRESS +: NB_REG_ADDRESS]),
            .i_src_used       (i_src_used[k]),
            .i_rd_id_ex       (i_rd_id_ex),
            .i_rd_ex_mem      (i_rd_ex_mem),
            .i_rd_mem_wb      (i_rd_mem_wb),
            .i_reg_wr_id_ex   (i_reg_wr_id_ex),
            .i_reg_wr_ex_mem  (i_reg_wr_ex_mem),
            .i_reg_wr_mem_wb  (i_reg_wr_mem_wb),
            .i_mem_read_id_ex (i_mem_read_id_ex),
            .i_mem_read_ex_mem(i_mem_read_ex_mem),
            .o_forward        (fwd_s[k*NB_FORWARDING_ENABLE +: NB_FORWARDING_ENABLE]),
            .o_need           (need_s[k*2 +: 2])
        );
    end

    // Worst-case stall need across all sources.
    always_comb begin
        need_max_s = 2'd0;
        for (int k = 0; k < N_SRC; k++) begin
            need_max_s = max_need(need_max_s, need_s[k*2 +: 2]);
        end
    end

    // Stall FSM next state and stall output. The detect cycle itself stalls
    // from IDLE; WAIT only covers the extra cycles of an adjacent load-use.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (need_max_s != 2'd0) begin
                    stall_s = 1'b1;
                    if (need_max_s == LOAD_USE_STALL) begin
                        state_d = ST_WAIT;
                        cnt_d   = LOAD_USE_STALL - 2'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (cnt_q <= 2'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d   = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
        // The squashed instruction no longer needs its operands.
        if (i_flush) begin
            stall_s = 1'b0;
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
        end else begin
            stall_s = stall_s;
        end
        // Debug freeze keeps state but the stall request stays visible.
        if (!i_enable) begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end else begin
            state_d = state_d;
        end
        if (!i_reset) begin
            stall_s = 1'b0;
        end else begin
            stall_s = stall_s;
        end
    end

    // Saturating stalled-cycle counter.
    always_comb begin
        count_d = count_q;
        if (stall_s && i_enable && (count_q != {NB_STALL_COUNT{1'b1}})) begin
            count_d = count_q + {{(NB_STALL_COUNT-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            count_q <= {NB_STALL_COUNT{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    // Output drive; forwarding is forced to the register file during reset.
    always_comb begin
        o_forward      = {(N_SRC*NB_FORWARDING_ENABLE){1'b0}};
        if (i_reset) begin
            o_forward = fwd_s;
        end else begin
            o_forward = {(N_SRC*NB_FORWARDING_ENABLE){1'b0}};
        end
        o_stall        = stall_s;
        o_bubble_id_ex = stall_s;
        o_stall_count  = count_q;
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
module tb_forwarding_hazard_unit;

    localparam int NB   = 5;
    localparam int NS   = 2;
    localparam int NC   = 4;
    localparam int MAXC = 15;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            flush;
    logic [NS*NB-1:0] src_addr;
    logic [NS-1:0]   src_used;
    logic [NB-1:0]   rd_id_ex, rd_ex_mem, rd_mem_wb;
    logic            wr_id_ex, wr_ex_mem, wr_mem_wb;
    logic            mr_id_ex, mr_ex_mem;
    logic [NS*2-1:0] fwd;
    logic            stall;
    logic            bubble;
    logic [NC-1:0]   count;

    int total;
    int bad;
    int m_wait;
    int m_count;

    forwarding_hazard_unit #(
        .NB_REG_ADDRESS      (NB),
        .N_SRC               (NS),
        .NB_FORWARDING_ENABLE(2),
        .NB_STALL_COUNT      (NC)
    ) dut (
        .i_clock          (clk),
        .i_reset          (rst_n),
        .i_enable         (en),
        .i_flush          (flush),
        .i_src_addr       (src_addr),
        .i_src_used       (src_used),
        .i_rd_id_ex       (rd_id_ex),
        .i_rd_ex_mem      (rd_ex_mem),
        .i_rd_mem_wb      (rd_mem_wb),
        .i_reg_wr_id_ex   (wr_id_ex),
        .i_reg_wr_ex_mem  (wr_ex_mem),
        .i_reg_wr_mem_wb  (wr_mem_wb),
        .i_mem_read_id_ex (mr_id_ex),
        .i_mem_read_ex_mem(mr_ex_mem),
        .o_forward        (fwd),
        .o_stall          (stall),
        .o_bubble_id_ex   (bubble),
        .o_stall_count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_fwd_one(int k);
        logic [NB-1:0] a;
        a = src_addr[k*NB +: NB];
        if (!src_used[k] || a == 0) return 2'b00;
        if (wr_id_ex  && rd_id_ex  == a) return 2'b11;
        if (wr_ex_mem && rd_ex_mem == a) return 2'b01;
        if (wr_mem_wb && rd_mem_wb == a) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [NS*2-1:0] ref_fwd();
        logic [NS*2-1:0] r;
        r = '0;
        if (rst_n) begin
            for (int k = 0; k < NS; k++) r[k*2 +: 2] = ref_fwd_one(k);
        end
        return r;
    endfunction

    function automatic int ref_need();
        int best;
        int n;
        logic [NB-1:0] a;
        best = 0;
        for (int k = 0; k < NS; k++) begin
            a = src_addr[k*NB +: NB];
            n = 0;
            if (src_used[k] && a != 0) begin
                if (wr_id_ex && rd_id_ex == a && mr_id_ex) n = 2;
                else if (wr_ex_mem && rd_ex_mem == a && mr_ex_mem) n = 1;
            end
            if (n > best) best = n;
        end
        return best;
    endfunction

    function automatic logic ref_stall();
        if (!rst_n) return 1'b0;
        if (flush) return 1'b0;
        if (m_wait > 0) return 1'b1;
        return (ref_need() > 0);
    endfunction

    task automatic tick();
        logic s;
        int n;
        s = ref_stall();
        n = ref_need();
        @(posedge clk);
        if (!rst_n) begin
            m_wait  = 0;
            m_count = 0;
        end else if (en) begin
            if (s && m_count < MAXC) m_count++;
            if (flush) m_wait = 0;
            else if (m_wait > 0) m_wait--;
            else if (n == 2) m_wait = 1;
        end
        #1;
    endtask

    task automatic clear_pipe();
        flush = 1'b0;
        src_addr = '0; src_used = '0;
        rd_id_ex = '0; rd_ex_mem = '0; rd_mem_wb = '0;
        wr_id_ex = 1'b0; wr_ex_mem = 1'b0; wr_mem_wb = 1'b0;
        mr_id_ex = 1'b0; mr_ex_mem = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1;
        clear_pipe();
        rd_id_ex = 5'd4; wr_id_ex = 1'b1; mr_id_ex = 1'b1;
        src_addr[0 +: NB] = 5'd4; src_used = 2'b01;
        tick();
        @(negedge clk);
        total++; if (stall !== 1'b0 || bubble !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b/%b want 0/0", stall, bubble); end
        total++; if (fwd !== 4'b0000) begin bad++; $display("FAIL reset_fwd: got %b want 0000", fwd); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        rst_n = 1'b1;
        clear_pipe();
        tick();
    endtask

    task automatic test_alu_forward();
        logic [NC-1:0] c0;
        logic [1:0] want;
        c0 = count;
        clear_pipe();
        src_addr[0 +: NB] = 5'd3; src_used = 2'b01;
        for (int i = 0; i < 4; i++) begin
            wr_id_ex  = (i == 0); rd_id_ex  = 5'd3;
            wr_ex_mem = (i <= 1); rd_ex_mem = 5'd3;
            wr_mem_wb = (i <= 2); rd_mem_wb = 5'd3;
            want = (i == 0) ? 2'b11 : (i == 1) ? 2'b01 : (i == 2) ? 2'b10 : 2'b00;
            @(negedge clk);
            total++; if (fwd[1:0] !== want || fwd !== ref_fwd()) begin bad++; $display("FAIL alu_fwd%0d: got %b want %b", i, fwd[1:0], want); end
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall%0d: got %b want 0", i, stall); end
            tick();
        end
        total++; if (count !== c0) begin bad++; $display("FAIL alu_count: got %0d want %0d", count, c0); end
    endtask

    task automatic test_load_adjacent();
        logic [NC-1:0] c0;
        c0 = count;
        clear_pipe();
        src_addr[NB +: NB] = 5'd5; src_used = 2'b10;
        rd_id_ex = 5'd5; wr_id_ex = 1'b1; mr_id_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (stall !== (i < 2) || bubble !== (i < 2) || stall !== ref_stall()) begin
                bad++; $display("FAIL adj_stall%0d: got %b/%b want %b", i, stall, bubble, (i < 2)); end
            if (i == 2) begin
                total++; if (fwd[3:2] !== 2'b10 || fwd !== ref_fwd()) begin bad++; $display("FAIL adj_fwd: got %b want 10", fwd[3:2]); end
            end
            tick();
            // pipeline advances only once the stall is over; here the load moves each cycle
            rd_mem_wb = rd_ex_mem; wr_mem_wb = wr_ex_mem;
            rd_ex_mem = rd_id_ex;  wr_ex_mem = wr_id_ex; mr_ex_mem = mr_id_ex;
            rd_id_ex = '0; wr_id_ex = 1'b0; mr_id_ex = 1'b0;
        end
        total++; if (count !== c0 + 4'd2 || count !== NC'(m_count)) begin bad++; $display("FAIL adj_count: got %0d want %0d", count, c0 + 4'd2); end
    endtask

    task automatic test_load_one_apart();
        logic [NC-1:0] c0;
        c0 = count;
        clear_pipe();
        src_addr[0 +: NB] = 5'd7; src_used = 2'b01;
        rd_ex_mem = 5'd7; wr_ex_mem = 1'b1; mr_ex_mem = 1'b1;
        @(negedge clk);
        total++; if (stall !== 1'b1 || bubble !== 1'b1) begin bad++; $display("FAIL one_stall: got %b/%b want 1/1", stall, bubble); end
        tick();
        rd_mem_wb = 5'd7; wr_mem_wb = 1'b1;
        rd_ex_mem = '0; wr_ex_mem = 1'b0; mr_ex_mem = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b0 || fwd[1:0] !== 2'b10) begin bad++; $display("FAIL one_after: got %b fwd %b want 0 fwd 10", stall, fwd[1:0]); end
        total++; if (count !== c0 + 4'd1) begin bad++; $display("FAIL one_count: got %0d want %0d", count, c0 + 4'd1); end
        for (int i = 0; i < 2; i++) begin
            clear_pipe();
            rd_ex_mem = (i == 0) ? 5'd0 : 5'd7; wr_ex_mem = 1'b1; mr_ex_mem = 1'b1;
            src_addr[0 +: NB] = rd_ex_mem; src_used = (i == 0) ? 2'b01 : 2'b00;
            @(negedge clk);
            total++; if (stall !== 1'b0 || fwd[1:0] !== 2'b00) begin bad++; $display("FAIL one_nostall%0d: got %b fwd %b want 0 fwd 00", i, stall, fwd[1:0]); end
            tick();
        end
    endtask

    task automatic test_flush();
        clear_pipe();
        src_addr[0 +: NB] = 5'd9; src_used = 2'b01;
        rd_id_ex = 5'd9; wr_id_ex = 1'b1; mr_id_ex = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        total++; if (stall !== 1'b0 || bubble !== 1'b0) begin bad++; $display("FAIL flush_detect: got %b/%b want 0/0", stall, bubble); end
        tick();
        flush = 1'b0; src_used = 2'b00;
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_idle: got %b want 0", stall); end
        tick();
        src_used = 2'b01;
        rd_id_ex = 5'd9; wr_id_ex = 1'b1; mr_id_ex = 1'b1;
        tick();
        rd_ex_mem = 5'd9; wr_ex_mem = 1'b1; mr_ex_mem = 1'b1;
        rd_id_ex = '0; wr_id_ex = 1'b0; mr_id_ex = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_wait_pre: got %b want 1", stall); end
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0 || bubble !== 1'b0) begin bad++; $display("FAIL flush_wait: got %b/%b want 0/0", stall, bubble); end
        tick();
        clear_pipe();
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_wait_after: got %b want 0", stall); end
        tick();
    endtask

    task automatic test_enable_freeze();
        logic [NC-1:0] c0;
        clear_pipe();
        src_addr[0 +: NB] = 5'd6; src_used = 2'b01;
        rd_id_ex = 5'd6; wr_id_ex = 1'b1; mr_id_ex = 1'b1;
        tick();
        rd_ex_mem = 5'd6; wr_ex_mem = 1'b1; mr_ex_mem = 1'b0;
        rd_id_ex = '0; wr_id_ex = 1'b0; mr_id_ex = 1'b0;
        en = 1'b0;
        c0 = count;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (stall !== 1'b1 || fwd[1:0] !== 2'b01) begin bad++; $display("FAIL en_hold%0d: got %b fwd %b want 1 fwd 01", i, stall, fwd[1:0]); end
            tick();
            total++; if (count !== c0) begin bad++; $display("FAIL en_count%0d: got %0d want %0d", i, count, c0); end
        end
        en = 1'b1;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL en_resume: got %b want 1", stall); end
        tick();
        @(negedge clk);
        total++; if (stall !== 1'b0 || count !== c0 + 4'd1) begin bad++; $display("FAIL en_done: got %b cnt %0d want 0 cnt %0d", stall, count, c0 + 4'd1); end
        tick();
    endtask

    task automatic test_saturation_and_reset();
        rst_n = 1'b0; clear_pipe();
        tick();
        rst_n = 1'b1;
        src_addr[0 +: NB] = 5'd2; src_used = 2'b01;
        rd_ex_mem = 5'd2; wr_ex_mem = 1'b1; mr_ex_mem = 1'b1;
        for (int i = 0; i < 40 && m_count < MAXC - 1; i++) tick();
        total++; if (count !== 4'd14) begin bad++; $display("FAIL sat_pre: got %0d want 14", count); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (count !== 4'd15) begin bad++; $display("FAIL sat_hold%0d: got %0d want 15", i, count); end
        end
        clear_pipe();
        src_addr[0 +: NB] = 5'd2; src_used = 2'b01;
        rd_id_ex = 5'd2; wr_id_ex = 1'b1; mr_id_ex = 1'b1;
        tick();
        rd_ex_mem = 5'd2; wr_ex_mem = 1'b1; mr_ex_mem = 1'b1;
        rd_id_ex = '0; wr_id_ex = 1'b0; mr_id_ex = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b0 || bubble !== 1'b0 || fwd !== 4'b0000) begin bad++; $display("FAIL rst_wait: got %b/%b fwd %b want 0/0 fwd 0000", stall, bubble, fwd); end
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
        rst_n = 1'b1; clear_pipe();
        @(negedge clk);
        total++; if (stall !== 1'b0 || bubble !== 1'b0) begin bad++; $display("FAIL rst_release: got %b/%b want 0/0", stall, bubble); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NS; k++) src_addr[k*NB +: NB] = NB'($urandom_range(0, 3));
            src_used  = NS'($urandom);
            rd_id_ex  = NB'($urandom_range(0, 3));
            rd_ex_mem = NB'($urandom_range(0, 3));
            rd_mem_wb = NB'($urandom_range(0, 3));
            wr_id_ex  = 1'($urandom); wr_ex_mem = 1'($urandom); wr_mem_wb = 1'($urandom);
            mr_id_ex  = 1'($urandom); mr_ex_mem = 1'($urandom);
            flush     = ($urandom_range(0, 9) == 0);
            en        = ($urandom_range(0, 7) != 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            @(negedge clk);
            total++; if (stall !== ref_stall() || bubble !== ref_stall()) begin bad++; $display("FAIL rnd_stall%0d: got %b/%b want %b", i, stall, bubble, ref_stall()); end
            total++; if (fwd !== ref_fwd()) begin bad++; $display("FAIL rnd_fwd%0d: got %b want %b", i, fwd, ref_fwd()); end
            tick();
            total++; if (count !== NC'(m_count)) begin bad++; $display("FAIL rnd_count%0d: got %0d want %0d", i, count, m_count); end
        end
        rst_n = 1'b1; en = 1'b1; clear_pipe();
    endtask

    initial begin
        total = 0; bad = 0; m_wait = 0; m_count = 0;
        rst_n = 1'b0; en = 1'b1;
        clear_pipe();
        #1;
        test_reset();
        test_alu_forward();
        test_load_adjacent();
        test_load_one_apart();
        test_flush();
        test_enable_freeze();
        test_saturation_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
